ram_port_b_arbiter: RTL and testbench

//  Shares the data port (port B) of the testbench dual-port RAM between two OBI-style requesters:
//  m0 = core data interface, m1 = TB loader/debug master.

---
 rtl/ram_port_b_arbiter_if.sv | 24 ++
 rtl/ram_port_b_arbiter.sv | 106 ++++++++++
 tb/tb_ram_port_b_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_b_arbiter_if.sv
// OBI-style request/response bundle for one master of the shared RAM port B.
// The master drives the request fields; the arbiter returns grant, rvalid and rdata.
interface ram_port_b_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 18
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_b_arbiter.sv
// Two-master arbiter for RAM port B: same-cycle grant, registered response routed
// back to the owner, and saturating grant/conflict statistics counters.
module ram_port_b_arbiter #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ram_port_b_arbiter_if.slave   m0,
  ram_port_b_arbiter_if.slave   m1,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic [CNT_WIDTH-1:0]  cnt_gnt0_o,
  output logic [CNT_WIDTH-1:0]  cnt_gnt1_o,
  output logic [CNT_WIDTH-1:0]  cnt_conflict_o
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  owner_e               r_last_gnt;
  owner_e               r_rsp_owner;
  logic                 r_rsp_valid;
  logic                 r_rsp_we;
  logic [CNT_WIDTH-1:0] r_cnt_gnt0;
  logic [CNT_WIDTH-1:0] r_cnt_gnt1;
  logic [CNT_WIDTH-1:0] r_cnt_conflict;

  logic w_conflict;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;
  logic w_rsp0;
  logic w_rsp1;

  // m0 wins a conflict under fixed priority, or in round-robin when m1 won last
  assign w_conflict = m0.req & m1.req;
  assign w_gnt0     = m0.req & (~m1.req | (FIXED_PRIO != 0) | (r_last_gnt == OWN_M1));
  assign w_gnt1     = m1.req & ~w_gnt0;
  assign w_any_gnt  = w_gnt0 | w_gnt1;

  always_comb begin
    ram_en_o    = w_any_gnt;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (w_gnt0) begin
      ram_addr_o  = m0.addr;
      ram_we_o    = m0.we;
      ram_be_o    = m0.be;
      ram_wdata_o = m0.wdata;
    end else if (w_gnt1) begin
      ram_addr_o  = m1.addr;
      ram_we_o    = m1.we;
      ram_be_o    = m1.be;
      ram_wdata_o = m1.wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_last_gnt     <= OWN_M1;
      r_rsp_valid    <= 1'b0;
      r_rsp_owner    <= OWN_M0;
      r_rsp_we       <= 1'b0;
      r_cnt_gnt0     <= '0;
      r_cnt_gnt1     <= '0;
      r_cnt_conflict <= '0;
    end else begin
      r_rsp_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_last_gnt  <= w_gnt1 ? OWN_M1 : OWN_M0;
        r_rsp_owner <= w_gnt1 ? OWN_M1 : OWN_M0;
        r_rsp_we    <= ram_we_o;
      end
      if (w_gnt0 && (r_cnt_gnt0 != '1)) r_cnt_gnt0 <= r_cnt_gnt0 + CNT_ONE;
      if (w_gnt1 && (r_cnt_gnt1 != '1)) r_cnt_gnt1 <= r_cnt_gnt1 + CNT_ONE;
      if (w_conflict && (r_cnt_conflict != '1)) r_cnt_conflict <= r_cnt_conflict + CNT_ONE;
    end
  end

  assign w_rsp0 = r_rsp_valid & (r_rsp_owner == OWN_M0);
  assign w_rsp1 = r_rsp_valid & (r_rsp_owner == OWN_M1);

  assign m0.gnt    = w_gnt0;
  assign m1.gnt    = w_gnt1;
  assign m0.rvalid = w_rsp0;
  assign m1.rvalid = w_rsp1;
  assign m0.rdata  = (w_rsp0 && !r_rsp_we) ? ram_rdata_i : '0;
  assign m1.rdata  = (w_rsp1 && !r_rsp_we) ? ram_rdata_i : '0;

  assign cnt_gnt0_o     = r_cnt_gnt0;
  assign cnt_gnt1_o     = r_cnt_gnt1;
  assign cnt_conflict_o = r_cnt_conflict;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Bench for ram_port_b_arbiter: directed vector table and random traffic against a
// transaction-level model, plus fixed-priority and counter-saturation instances.
module tb_ram_port_b_arbiter;

  localparam int unsigned AW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_load = 1'b0;
  always #5 clk = ~clk;

  ram_port_b_arbiter_if #(.ADDR_WIDTH(AW)) a0 ();
  ram_port_b_arbiter_if #(.ADDR_WIDTH(AW)) a1 ();
  ram_port_b_arbiter_if #(.ADDR_WIDTH(AW)) b0 ();
  ram_port_b_arbiter_if #(.ADDR_WIDTH(AW)) b1 ();
  ram_port_b_arbiter_if #(.ADDR_WIDTH(AW)) c0 ();
  ram_port_b_arbiter_if #(.ADDR_WIDTH(AW)) c1 ();

  logic          a_en, a_we, b_en, b_we, c_en, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [3:0]    a_be, b_be, c_be;
  logic [31:0]   a_wdata, b_wdata, c_wdata;
  logic [31:0]   a_rdata;
  logic [31:0]   b_rdata = 32'hCAFE_F00D;
  logic [31:0]   c_rdata = 32'h0;
  logic [31:0]   a_cg0, a_cg1, a_cc, b_cg0, b_cg1, b_cc;
  logic [3:0]    c_cg0, c_cg1, c_cc;

  ram_port_b_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0), .CNT_WIDTH(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .m0(a0.slave), .m1(a1.slave),
    .ram_en_o(a_en), .ram_addr_o(a_addr), .ram_we_o(a_we), .ram_be_o(a_be),
    .ram_wdata_o(a_wdata), .ram_rdata_i(a_rdata),
    .cnt_gnt0_o(a_cg0), .cnt_gnt1_o(a_cg1), .cnt_conflict_o(a_cc));

  ram_port_b_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1), .CNT_WIDTH(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .m0(b0.slave), .m1(b1.slave),
    .ram_en_o(b_en), .ram_addr_o(b_addr), .ram_we_o(b_we), .ram_be_o(b_be),
    .ram_wdata_o(b_wdata), .ram_rdata_i(b_rdata),
    .cnt_gnt0_o(b_cg0), .cnt_gnt1_o(b_cg1), .cnt_conflict_o(b_cc));

  ram_port_b_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0), .CNT_WIDTH(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .m0(c0.slave), .m1(c1.slave),
    .ram_en_o(c_en), .ram_addr_o(c_addr), .ram_we_o(c_we), .ram_be_o(c_be),
    .ram_wdata_o(c_wdata), .ram_rdata_i(c_rdata),
    .cnt_gnt0_o(c_cg0), .cnt_gnt1_o(c_cg1), .cnt_conflict_o(c_cc));

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return {8'hA5, i[7:0], 8'h5A, ~i[7:0]};
  endfunction

  // RAM attached to dut_a: 256 words, registered read
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (a_en) begin
      if (a_we) begin
        for (int b = 0; b < 4; b++)
          if (a_be[b]) mem[a_addr[9:2]][8*b +: 8] <= a_wdata[8*b +: 8];
      end else begin
        a_rdata <= mem[a_addr[9:2]];
      end
    end
  end

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
  } mreq_t;

  typedef struct {
    logic        rst;
    mreq_t       m0;
    mreq_t       m1;
    logic [1:0]  eg;
    logic [1:0]  erv;
    logic [31:0] erd0;
    logic [31:0] erd1;
  } vec_t;

  localparam mreq_t IDLE = '0;

  function automatic mreq_t rd(input logic [AW-1:0] a);
    mreq_t r = '0;
    r.req = 1'b1; r.addr = a; r.be = 4'hF;
    return r;
  endfunction

  function automatic mreq_t wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    mreq_t r = '0;
    r.req = 1'b1; r.addr = a; r.we = 1'b1; r.be = be; r.wdata = d;
    return r;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of dut_a
  logic [31:0] ref_mem [256];
  int          m_last = 1;
  bit          m_pv = 0;
  int          m_owner = 0;
  bit          m_we = 0;
  logic [31:0] m_rd = '0;
  longint      m_c0 = 0, m_c1 = 0, m_cc = 0;
  logic [1:0]  obs_gnt, obs_rv;
  logic [31:0] obs_rd0, obs_rd1;

  function automatic longint sat_inc(input longint v);
    return (v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  task automatic drive_a(input mreq_t r0, input mreq_t r1);
    a0.req = r0.req; a0.addr = r0.addr; a0.we = r0.we; a0.be = r0.be; a0.wdata = r0.wdata;
    a1.req = r1.req; a1.addr = r1.addr; a1.we = r1.we; a1.be = r1.be; a1.wdata = r1.wdata;
  endtask

  // One cycle on dut_a, entered and left at negedge
  task automatic step_a(input mreq_t r0, input mreq_t r1, input logic rst_in);
    int    win;
    mreq_t w;
    int    idx;
    drive_a(r0, r1);
    rst_n = rst_in;
    #2;
    win = -1;
    if (r0.req && r1.req) win = (m_last == 1) ? 0 : 1;
    else if (r0.req)      win = 0;
    else if (r1.req)      win = 1;
    w = (win == 0) ? r0 : (win == 1) ? r1 : IDLE;
    obs_gnt = {a1.gnt, a0.gnt};
    chk("gnt", obs_gnt, (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00);
    chk("ram_en", a_en, win >= 0);
    chk("ram_addr", a_addr, w.addr);
    chk("ram_we", a_we, w.we);
    chk("ram_be", a_be, w.be);
    chk("ram_wdata", a_wdata, w.wdata);
    @(posedge clk);
    idx = int'(w.addr[9:2]);
    if (!rst_in) begin
      m_last = 1; m_pv = 0; m_c0 = 0; m_c1 = 0; m_cc = 0;
    end else begin
      if (r0.req && r1.req) m_cc = sat_inc(m_cc);
      m_pv = (win >= 0);
      if (win >= 0) begin
        m_last = win; m_owner = win; m_we = w.we; m_rd = ref_mem[idx];
        if (win == 0) m_c0 = sat_inc(m_c0); else m_c1 = sat_inc(m_c1);
      end
    end
    if (win >= 0 && w.we)
      for (int b = 0; b < 4; b++)
        if (w.be[b]) ref_mem[idx][8*b +: 8] = w.wdata[8*b +: 8];
    #1;
    obs_rv  = {a1.rvalid, a0.rvalid};
    obs_rd0 = a0.rdata;
    obs_rd1 = a1.rdata;
    chk("rvalid", obs_rv, {m_pv && m_owner == 1, m_pv && m_owner == 0});
    chk("rdata0", obs_rd0, (m_pv && m_owner == 0 && !m_we) ? m_rd : 32'h0);
    chk("rdata1", obs_rd1, (m_pv && m_owner == 1 && !m_we) ? m_rd : 32'h0);
    chk("cnt_gnt0", a_cg0, m_c0);
    chk("cnt_gnt1", a_cg1, m_c1);
    chk("cnt_conflict", a_cc, m_cc);
    @(negedge clk);
  endtask

  vec_t tbl [14];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step_a(tbl[i].m0, tbl[i].m1, tbl[i].rst);
      chk($sformatf("row%0d gnt", i), obs_gnt, tbl[i].eg);
      chk($sformatf("row%0d rvalid", i), obs_rv, tbl[i].erv);
      chk($sformatf("row%0d rdata0", i), obs_rd0, tbl[i].erd0);
      chk($sformatf("row%0d rdata1", i), obs_rd1, tbl[i].erd1);
    end
  endtask

  function automatic mreq_t rnd_req();
    mreq_t r;
    r.req   = ($urandom_range(0, 9) < 7);
    r.addr  = AW'($urandom);
    r.we    = $urandom_range(0, 1) == 1;
    r.be    = 4'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    drive_a(IDLE, IDLE);
    {b0.req, b0.addr, b0.we, b0.be, b0.wdata} = '0;
    {b1.req, b1.addr, b1.we, b1.be, b1.wdata} = '0;
    {c0.req, c0.addr, c0.we, c0.be, c0.wdata} = '0;
    {c1.req, c1.addr, c1.we, c1.be, c1.wdata} = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    tbl[0]  = '{1'b0, IDLE, IDLE, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, IDLE, IDLE, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, rd(18'h10), IDLE, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0};
    tbl[3]  = '{1'b1, IDLE, IDLE, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, IDLE, wr(18'h20, 4'b0011, 32'h1234_5678), 2'b10, 2'b10, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, rd(18'h20), IDLE, 2'b01, 2'b01, 32'hA508_5678, 32'h0};
    tbl[6]  = '{1'b0, IDLE, IDLE, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, rd(18'h10), rd(18'h14), 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0};
    tbl[8]  = '{1'b1, rd(18'h10), rd(18'h14), 2'b10, 2'b10, 32'h0, 32'hA505_5AFA};
    tbl[9]  = '{1'b1, rd(18'h10), rd(18'h14), 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0};
    tbl[10] = '{1'b1, rd(18'h10), rd(18'h14), 2'b10, 2'b10, 32'h0, 32'hA505_5AFA};
    tbl[11] = '{1'b1, rd(18'h10), IDLE, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0};
    tbl[12] = '{1'b0, rd(18'h10), IDLE, 2'b01, 2'b00, 32'h0, 32'h0};
    tbl[13] = '{1'b1, rd(18'h10), rd(18'h14), 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0};

    @(negedge clk);
    mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;

    run_rows(0, 10);
    chk("rr cnt_conflict", a_cc, 64'd4);
    chk("rr cnt_gnt0", a_cg0, 64'd2);
    chk("rr cnt_gnt1", a_cg1, 64'd2);
    run_rows(11, 12);
    chk("reset cnt_gnt0", a_cg0, 64'd0);
    chk("reset cnt_conflict", a_cc, 64'd0);
    run_rows(13, 13);

    for (int i = 0; i < 300; i++)
      step_a(rnd_req(), rnd_req(), $urandom_range(0, 39) != 0);
    step_a(IDLE, IDLE, 1'b1);

    // Fixed priority: m0 wins every conflict, m1 holds its write until m0 drops
    b0.req = 1'b1; b0.addr = 18'h40; b0.we = 1'b0; b0.be = 4'hF;
    b1.req = 1'b1; b1.addr = 18'h80; b1.we = 1'b1; b1.be = 4'hF; b1.wdata = 32'h5555_AAAA;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("fp gnt", {b1.gnt, b0.gnt}, 2'b01);
      chk("fp ram_addr", b_addr, 18'h40);
      chk("fp ram_we", b_we, 1'b0);
      @(posedge clk); #1;
      chk("fp rvalid", {b1.rvalid, b0.rvalid}, 2'b01);
      chk("fp rdata0", b0.rdata, 32'hCAFE_F00D);
      @(negedge clk);
    end
    b0.req = 1'b0;
    #2;
    chk("fp m1 gnt", {b1.gnt, b0.gnt}, 2'b10);
    chk("fp m1 ram_addr", b_addr, 18'h80);
    chk("fp m1 ram_wdata", b_wdata, 32'h5555_AAAA);
    @(posedge clk); #1;
    chk("fp m1 rvalid", {b1.rvalid, b0.rvalid}, 2'b10);
    chk("fp m1 rdata", b1.rdata, 32'h0);
    chk("fp cnt_conflict", b_cc, 64'd3);
    chk("fp cnt_gnt0", b_cg0, 64'd3);
    chk("fp cnt_gnt1", b_cg1, 64'd1);
    @(negedge clk);
    b1.req = 1'b0;

    // 4-bit counters saturate at 15
    c0.req = 1'b1; c0.addr = 18'h4; c0.be = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat cnt_gnt0 k=%0d", k), c_cg0, (k > 15) ? 64'd15 : 64'(k));
      @(negedge clk);
    end
    chk("sat cnt_conflict", c_cc, 64'd0);
    c0.req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
